prog_loader: RTL and testbench

// - Writer side of the 256x16 instruction store: accepts a framed byte stream
//   (host/UART side), assembles 16-bit instruction words, writes them into a

---
 rtl/prog_loader_if.sv | 18 +
 rtl/prog_loader.sv | 81 ++++++++
 tb/tb_prog_loader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and program-memory write bus of prog_loader.
// master = host/stream side, slave = loader side.
interface prog_loader_if #(parameter int ADDR_W = 8, parameter int DATA_W = 16);
    logic [7:0] in_data;
    logic in_valid;
    logic in_ready;
    logic mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic cpu_hold;
    logic busy;
    logic done;
    logic err;
    modport master (output in_data, in_valid,
                    input in_ready, mem_we, mem_addr, mem_wd, cpu_hold, busy, done, err);
    modport slave (input in_data, in_valid,
                   output in_ready, mem_we, mem_addr, mem_wd, cpu_hold, busy, done, err);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: framed byte stream -> 16-bit program-memory writes, holding the CPU while loading.
// Optional trailing checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input logic clk,
    input logic rst,
    prog_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, LEN, HI, LO, CSUM, END} state_t;
    state_t state, nxt;
    logic acc, last;
    logic [ADDR_W-1:0] ptr, cnt;
    logic [7:0] hi;
    assign bus.in_ready = !rst && state != END;
    assign acc = bus.in_valid && bus.in_ready;
    // LEN=0 starts the counter at 0, so it wraps through 2^ADDR_W words before reaching 1
    assign last = cnt == ADDR_W'(1);
    assign bus.cpu_hold = state != IDLE && state != END;
    assign bus.busy = state != IDLE && state != END;
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = acc && bus.in_data == SYNC_BYTE ? ADDR : IDLE;
            ADDR: nxt = acc ? LEN : ADDR;
            LEN: nxt = acc ? HI : LEN;
            HI: nxt = acc ? LO : HI;
`ifdef PROG_LOADER_CHECKSUM_EN
            LO: nxt = acc ? (last ? CSUM : HI) : LO;
            CSUM: nxt = acc ? END : CSUM;
`else
            LO: nxt = acc ? (last ? END : HI) : LO;
`endif
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            cnt <= '0;
            hi <= '0;
            bus.mem_we <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wd <= '0;
        end else begin
            state <= nxt;
            bus.mem_we <= state == LO && acc;
            if (acc && state == ADDR) ptr <= ADDR_W'(bus.in_data);
            if (acc && state == LEN) cnt <= ADDR_W'(bus.in_data);
            if (acc && state == HI) hi <= bus.in_data;
            if (acc && state == LO) begin
                bus.mem_addr <= ptr;
                bus.mem_wd <= DATA_W'({hi, bus.in_data});
                ptr <= ptr + ADDR_W'(1);
                cnt <= cnt - ADDR_W'(1);
            end
        end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic bad;
    // sum covers ADDR, LEN and payload; the running value is compared when CSUM arrives
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            sum <= '0;
            bad <= 1'b0;
        end else if (acc) begin
            sum <= sum + bus.in_data;
            bad <= state == CSUM && bus.in_data != sum;
        end
    end
    assign bus.done = state == END && !bad;
    assign bus.err = state == END && bad;
`else
    assign bus.done = state == END;
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames against prog_loader; write log compared to expected words.
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_bad = 0;
    int dn = 0;
    int er = 0;
    logic [7:0] qa[$];
    logic [15:0] qd[$];
    logic [15:0] w[256];
    prog_loader_if bus();
    prog_loader dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.mem_we) begin
            qa.push_back(bus.mem_addr);
            qd.push_back(bus.mem_wd);
        end
        if (bus.done) dn++;
        if (bus.err) er++;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask
    task automatic put(input logic [7:0] b, input int gap);
        int n = 0;
        bus.in_data = ~b;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.in_data = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n == 8) chk("ready_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask
    task automatic clear();
        qa.delete();
        qd.delete();
        dn = 0;
        er = 0;
    endtask
    task automatic frame(input logic [7:0] a, input logic [7:0] len, input int n, input int gap, input bit flip);
        logic [7:0] s;
        s = a + len;
        put(8'hA5, gap);
        chk("hold_sync", 32'(bus.cpu_hold), 32'd1);
        chk("busy_sync", 32'(bus.busy), 32'd1);
        put(a, gap);
        put(len, gap);
        for (int i = 0; i < n; i++) begin
            put(w[i][15:8], gap);
            put(w[i][7:0], gap);
            s = s + w[i][15:8] + w[i][7:0];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        put(s ^ {7'd0, flip}, gap);
        chk("err_end", 32'(bus.err), 32'(flip));
`else
        chk("we_end", 32'(bus.mem_we), 32'd1);
        chk("err_end", 32'(bus.err), 32'd0);
`endif
        chk("done_end", 32'(bus.done), 32'(!flip));
        chk("hold_end", 32'(bus.cpu_hold), 32'd0);
        chk("ready_end", 32'(bus.in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("done_cnt", 32'(dn), 32'(!flip));
    endtask
    task automatic verify(input logic [7:0] a, input int n);
        chk("nwr", 32'(qa.size()), 32'(n));
        for (int i = 0; i < n && i < qa.size(); i++) begin
            chk("addr", 32'(qa[i]), 32'(8'(a + 8'(i))));
            chk("data", 32'(qd[i]), 32'(w[i]));
        end
    endtask
    task automatic rst_vals(input string tag);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_wd"}, 32'(bus.mem_wd), 32'd0);
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    endtask
    initial begin
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_up", 32'(bus.in_ready), 32'd1);
        // basic load
        clear();
        w[0] = 16'h1234;
        w[1] = 16'hABCD;
        frame(8'h10, 8'h02, 2, 0, 1'b0);
        verify(8'h10, 2);
        // pointer wraps past 0xFF
        clear();
        w[0] = 16'h0001;
        w[1] = 16'h0002;
        frame(8'hFF, 8'h02, 2, 0, 1'b0);
        verify(8'hFF, 2);
        // junk before sync, then in_valid toggling every cycle
        clear();
        put(8'h00, 1);
        put(8'h3C, 1);
        chk("junk_idle", 32'(bus.busy), 32'd0);
        w[0] = 16'h1234;
        w[1] = 16'hABCD;
        frame(8'h10, 8'h02, 2, 1, 1'b0);
        verify(8'h10, 2);
        // sync value as payload is plain data
        clear();
        w[0] = 16'hA5A5;
        frame(8'h40, 8'h01, 1, 0, 1'b0);
        verify(8'h40, 1);
        // LEN=0 -> 256 words
        clear();
        for (int i = 0; i < 256; i++) w[i] = {8'(i), ~8'(i)};
        frame(8'h00, 8'h00, 256, 0, 1'b0);
        verify(8'h00, 256);
        // reset after HI byte of word 2
        clear();
        w[0] = 16'h1122;
        put(8'hA5, 0);
        put(8'h20, 0);
        put(8'h02, 0);
        put(8'h11, 0);
        put(8'h22, 0);
        put(8'h33, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_vals("mid");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        verify(8'h20, 1);
        chk("mid_done", 32'(dn), 32'd0);
        clear();
        w[0] = 16'h5566;
        w[1] = 16'h7788;
        frame(8'h30, 8'h02, 2, 0, 1'b0);
        verify(8'h30, 2);
`ifdef PROG_LOADER_CHECKSUM_EN
        clear();
        w[0] = 16'h1234;
        w[1] = 16'hABCD;
        frame(8'h10, 8'h02, 2, 0, 1'b1);
        verify(8'h10, 2);
        chk("err_cnt", 32'(er), 32'd1);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
